program_loader: RTL and testbench

- Fills the byte-wide instruction memory of the fetch stage from a serial byte stream (UART receiver output) before the pipeline runs.
- Sits directly upstream of instruction fetch. Drives its instruction-memory write enable, address and data inputs.
- Holds the pipeline halted while a load is in progress.
- Ends the load on the HALT instruction word, or flags an error when memory capacity is exceeded.

---
 rtl/program_loader.sv | 164 ++++++++++++++++
 tb/tb_program_loader.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
//
// Fills the byte-wide instruction memory of the fetch stage from a serial
// byte stream (UART receiver output) before the pipeline runs. Bytes are
// written in arrival order to ascending addresses. They are also assembled
// big-endian into 32-bit words. A load ends when a complete, word-aligned
// HALT_WORD has been received. It also ends, with an error, when the last
// memory byte is written without HALT_WORD having been seen.
//
// Ports:
//   i_clk                    clock, all logic on the rising edge
//   i_reset                  synchronous, active-high reset
//   i_start                  begin a new load (sampled in IDLE, DONE, ERROR)
//   i_rx_data[7:0]           received byte
//   i_rx_valid               one-cycle strobe qualifying i_rx_data
//   o_write_instruction_mem  instruction-memory write enable (one cycle per byte)
//   o_instruction_mem_addr   byte write address, zero-extended
//   o_instruction_mem_data   write data, byte in [7:0], upper bits zero
//   o_halt                   pipeline freeze, high exactly while loading
//   o_done                   load terminated by HALT_WORD
//   o_error                  capacity exhausted without HALT_WORD
//   o_word_count[6:0]        complete words written, including HALT
// ---------------------------------------------------------------------------
module program_loader #(
    parameter int          ADDR_WIDTH = 8,
    parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic        o_write_instruction_mem,
    output logic [31:0] o_instruction_mem_addr,
    output logic [31:0] o_instruction_mem_data,
    output logic        o_halt,
    output logic        o_done,
    output logic        o_error,
    output logic [6:0]  o_word_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DONE  = 2'd2,
        S_ERROR = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [1:0]            bcnt_q, bcnt_d;
    logic [31:0]           shreg_q, shreg_d;
    logic                  wr_q, wr_d;
    logic [31:0]           addr_q, addr_d;
    logic [31:0]           data_q, data_d;
    logic                  halt_q, halt_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic [6:0]            wcnt_q, wcnt_d;

    // Pointer after the byte currently being accepted; wraps to zero once
    // the last memory address has been written.
    logic [ADDR_WIDTH-1:0] ptr_inc;
    logic [31:0]           shreg_inc;

    assign ptr_inc   = ptr_q + 1'b1;
    assign shreg_inc = {shreg_q[23:0], i_rx_data};

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        bcnt_d  = bcnt_q;
        shreg_d = shreg_q;
        wr_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        done_d  = done_q;
        error_d = error_q;
        wcnt_d  = wcnt_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                // Byte strobes are ignored here; only a start does anything.
                if (i_start) begin
                    state_d = S_LOAD;
                    ptr_d   = '0;
                    bcnt_d  = 2'd0;
                    shreg_d = 32'd0;
                    wcnt_d  = 7'd0;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                end
            end

            S_LOAD: begin
                // i_start is deliberately not looked at while loading.
                if (i_rx_valid) begin
                    wr_d    = 1'b1;
                    addr_d  = {{(32-ADDR_WIDTH){1'b0}}, ptr_q};
                    data_d  = {24'd0, i_rx_data};
                    ptr_d   = ptr_inc;
                    shreg_d = shreg_inc;
                    bcnt_d  = bcnt_q + 2'd1;

                    // Only a fully assembled, aligned word can end the load.
                    // HALT as the very last word takes priority over overflow.
                    if (bcnt_q == 2'd3) begin
                        wcnt_d = wcnt_q + 7'd1;
                        if (shreg_inc == HALT_WORD) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else if (ptr_inc == '0) begin
                            state_d = S_ERROR;
                            error_d = 1'b1;
                        end
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase

        // Registered copy of "next state is LOAD", so o_halt tracks the state.
        halt_d = (state_d == S_LOAD);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            bcnt_q  <= 2'd0;
            shreg_q <= 32'd0;
            wr_q    <= 1'b0;
            addr_q  <= 32'd0;
            data_q  <= 32'd0;
            halt_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            wcnt_q  <= 7'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            bcnt_q  <= bcnt_d;
            shreg_q <= shreg_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            halt_q  <= halt_d;
            done_q  <= done_d;
            error_q <= error_d;
            wcnt_q  <= wcnt_d;
        end
    end

    assign o_write_instruction_mem = wr_q;
    assign o_instruction_mem_addr  = addr_q;
    assign o_instruction_mem_data  = data_q;
    assign o_halt                  = halt_q;
    assign o_done                  = done_q;
    assign o_error                 = error_q;
    assign o_word_count            = wcnt_q;

endmodule

// File: tb/tb_program_loader.sv
// ---------------------------------------------------------------------------
// tb_program_loader
//
// Directed bench for program_loader. Each byte that should be written is
// pushed as {addr, data} into a queue when it is driven. A separate monitor
// pops and compares on every write pulse. Status outputs are checked
// directly at chosen points with hand-computed values.
// ---------------------------------------------------------------------------
module tb_program_loader;

    logic        i_clk;
    logic        i_reset;
    logic        i_start;
    logic [7:0]  i_rx_data;
    logic        i_rx_valid;
    logic        o_write_instruction_mem;
    logic [31:0] o_instruction_mem_addr;
    logic [31:0] o_instruction_mem_data;
    logic        o_halt;
    logic        o_done;
    logic        o_error;
    logic [6:0]  o_word_count;

    program_loader #(
        .ADDR_WIDTH (8),
        .HALT_WORD  (32'hFFFF_FFFF)
    ) dut (
        .i_clk                   (i_clk),
        .i_reset                 (i_reset),
        .i_start                 (i_start),
        .i_rx_data               (i_rx_data),
        .i_rx_valid              (i_rx_valid),
        .o_write_instruction_mem (o_write_instruction_mem),
        .o_instruction_mem_addr  (o_instruction_mem_addr),
        .o_instruction_mem_data  (o_instruction_mem_data),
        .o_halt                  (o_halt),
        .o_done                  (o_done),
        .o_error                 (o_error),
        .o_word_count            (o_word_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [63:0] exp_q[$];
    logic [31:0] exp_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every write pulse must match the oldest expected write.
    always @(negedge i_clk) begin
        if (o_write_instruction_mem === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                         o_instruction_mem_addr, o_instruction_mem_data);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("write_addr", o_instruction_mem_addr, e[63:32]);
                check("write_data", o_instruction_mem_data, e[31:0]);
            end
        end
    end

    // All tasks are entered at a falling edge and return at a falling edge.
    task automatic tick(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic send(input logic [7:0] b, input bit exp_wr);
        i_rx_valid = 1'b1;
        i_rx_data  = b;
        if (exp_wr) begin
            exp_q.push_back({exp_addr, 24'd0, b});
            exp_addr = exp_addr + 32'd1;
        end
        @(negedge i_clk);
        i_rx_valid = 1'b0;
    endtask

    task automatic send_n(input int n, input logic [7:0] b, input bit exp_wr);
        for (int k = 0; k < n; k++) send(b, exp_wr);
    endtask

    task automatic start_load();
        i_start = 1'b1;
        @(negedge i_clk);
        i_start  = 1'b0;
        exp_addr = 32'd0;
    endtask

    task automatic check_drained(input string name);
        tick(1);
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        i_reset    = 1'b1;
        i_start    = 1'b0;
        i_rx_data  = 8'd0;
        i_rx_valid = 1'b0;
        exp_addr   = 32'd0;
        tick(3);
        i_reset = 1'b0;

        // Reset state
        check("rst_wr",    o_write_instruction_mem, 0);
        check("rst_addr",  o_instruction_mem_addr, 0);
        check("rst_data",  o_instruction_mem_data, 0);
        check("rst_halt",  o_halt, 0);
        check("rst_done",  o_done, 0);
        check("rst_error", o_error, 0);
        check("rst_wcnt",  o_word_count, 0);

        // Strobes while idle are ignored
        send(8'h55, 1'b0);
        tick(1);
        check("idle_halt", o_halt, 0);

        // Test 1: two words, second one is HALT
        start_load();
        check("t1_halt_start", o_halt, 1);
        send(8'h20, 1'b1); tick(1);
        send(8'h01, 1'b1); tick(1);
        send(8'h00, 1'b1); tick(1);
        send(8'h05, 1'b1);
        check("t1_wcnt1", o_word_count, 1);
        check("t1_done_mid", o_done, 0);
        check("t1_halt_mid", o_halt, 1);
        tick(1);
        send_n(4, 8'hFF, 1'b1);
        check("t1_done", o_done, 1);
        check("t1_halt_end", o_halt, 0);
        check("t1_error", o_error, 0);
        check("t1_wcnt", o_word_count, 2);
        tick(2);
        check("t1_done_hold", o_done, 1);
        check_drained("t1_drained");

        // Test 2: FF FF FF 00 is not HALT; only the aligned FFFFFFFF is
        start_load();
        check("t2_done_clr", o_done, 0);
        check("t2_wcnt_clr", o_word_count, 0);
        send_n(3, 8'hFF, 1'b1);
        send(8'h00, 1'b1);
        check("t2_done_mid", o_done, 0);
        check("t2_halt_mid", o_halt, 1);
        send_n(4, 8'hFF, 1'b1);
        check("t2_done", o_done, 1);
        check("t2_wcnt", o_word_count, 2);
        check_drained("t2_drained");

        // Test 3: capacity overflow
        start_load();
        send_n(255, 8'h00, 1'b1);
        check("t3_halt_pre", o_halt, 1);
        check("t3_err_pre", o_error, 0);
        send(8'h00, 1'b1);
        check("t3_error", o_error, 1);
        check("t3_done", o_done, 0);
        check("t3_halt", o_halt, 0);
        check("t3_wcnt", o_word_count, 64);
        send(8'h00, 1'b0);
        tick(2);
        check("t3_err_hold", o_error, 1);
        check_drained("t3_drained");

        // Test 4: HALT as the final word wins over overflow
        start_load();
        check("t4_err_clr", o_error, 0);
        send_n(252, 8'h00, 1'b1);
        send_n(4, 8'hFF, 1'b1);
        check("t4_done", o_done, 1);
        check("t4_error", o_error, 0);
        check("t4_wcnt", o_word_count, 64);
        check("t4_halt", o_halt, 0);
        check_drained("t4_drained");

        // Test 5: reset mid-load aborts
        start_load();
        send_n(6, 8'hA5, 1'b1);
        i_reset = 1'b1;
        tick(1);
        i_reset = 1'b0;
        check("t5_wr",    o_write_instruction_mem, 0);
        check("t5_addr",  o_instruction_mem_addr, 0);
        check("t5_data",  o_instruction_mem_data, 0);
        check("t5_halt",  o_halt, 0);
        check("t5_done",  o_done, 0);
        check("t5_error", o_error, 0);
        check("t5_wcnt",  o_word_count, 0);
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        tick(2);
        check("t5_idle_halt", o_halt, 0);
        start_load();
        send(8'h11, 1'b1);
        send(8'h22, 1'b1);
        send(8'h33, 1'b1);
        send(8'h44, 1'b1);
        check("t5_wcnt1", o_word_count, 1);
        send_n(4, 8'hFF, 1'b1);
        check("t5_done_end", o_done, 1);
        check_drained("t5_drained");

        // Test 6: back-to-back bytes, i_start during LOAD ignored
        start_load();
        send(8'h01, 1'b1);
        send(8'h02, 1'b1);
        i_start = 1'b1;
        send(8'h03, 1'b1);
        i_start = 1'b0;
        send(8'h04, 1'b1);
        send_n(4, 8'hFF, 1'b1);
        check("t6_done", o_done, 1);
        check("t6_wcnt", o_word_count, 2);
        check("t6_halt", o_halt, 0);
        tick(1);
        start_load();
        check("t6_done_clr", o_done, 0);
        check("t6_halt_restart", o_halt, 1);
        send(8'hAA, 1'b1);
        check_drained("t6_drained");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
